// File: rtl/mux_rr_arb_if.sv
// Channel bundle for mux_rr_arb: CHANNELS producer beats in, one registered beat out.
// master drives producers and the consumer ready; slave is the mux itself.
interface mux_rr_arb_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_rr_arb.sv
// Registered N:1 mux, round-robin or forced select; 1-cycle latency, 1 beat/cycle, inputs stall while a held beat waits.
// MUX_RR_ARB_CNT_EN adds the xfer_count output-beat counter.
module mux_rr_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
`ifdef MUX_RR_ARB_CNT_EN
  output logic [15:0]     xfer_count,
`endif
  mux_rr_arb_if.slave     bus
);

  logic [SELW-1:0]     ptr;
  logic                load;
  logic                gnt_vld;
  logic [SELW-1:0]     gnt_idx;
  logic [CHANNELS-1:0] gnt_oh;
  logic [WIDTH-1:0]    gnt_dat;
  logic [CHANNELS-1:0] rot;
  int                  rr_idx;

  assign load = !bus.out_valid || bus.out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    gnt_dat = '0;
    rr_idx  = 0;
    // rot[k] is the request of channel ptr+k, so the first set bit wins
    rot     = CHANNELS'({bus.in_valid, bus.in_valid} >> ptr);
    if (force_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(force_sel) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!gnt_vld && rot[k]) begin
          gnt_vld = 1'b1;
          rr_idx  = int'(ptr) + k;
          if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
          gnt_idx = SELW'(rr_idx);
        end
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_vld && int'(gnt_idx) == i) begin
        gnt_oh[i] = 1'b1;
        gnt_dat   = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.in_ready = (reset_n && load) ? gnt_oh : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (load) begin
      if (gnt_vld) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= gnt_dat;
        bus.out_sel   <= gnt_idx;
        if (!force_en)
          ptr <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_ARB_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      xfer_count <= '0;
    else if (bus.out_valid && bus.out_ready)
      xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb (8 x 16-bit): round-robin, sparse, backpressure, forced select, async reset, optional counter.
module tb_mux_rr_arb;
  localparam int W = 16;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       force_en = 1'b0;
  logic [2:0] force_sel = 3'd0;
`ifdef MUX_RR_ARB_CNT_EN
  logic [15:0] xfer_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mux_rr_arb_if #(.WIDTH(W), .CHANNELS(N)) bus ();

  mux_rr_arb #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .force_en  (force_en),
    .force_sel (force_sel),
`ifdef MUX_RR_ARB_CNT_EN
    .xfer_count(xfer_count),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(i + 1);
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset state, with every channel requesting
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(bus.in_ready), 32'h01);

    // Round-robin, all valid: 1..8 then wrap
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rr_data",  32'(bus.out_data),  32'((k % N) + 1));
      check("rr_sel",   32'(bus.out_sel),   32'(k % N));
      check("rr_valid", 32'(bus.out_valid), 32'd1);
      check("rr_ready", 32'(bus.in_ready),  32'(1 << ((k + 1) % N)));
    end

    // Sparse: channels 2 and 5 only; pointer currently at 2
    bus.in_valid = 8'b0010_0100;
    #1;
    check("sp_first_ready", 32'(bus.in_ready), 32'h04);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("sp_data",  32'(bus.out_data), (j % 2 == 0) ? 32'd3 : 32'd6);
      check("sp_ready", 32'(bus.in_ready), (j % 2 == 0) ? 32'h20 : 32'h04);
    end

    // Backpressure after the first beat
    bus.in_valid = 8'hFF;
    do_reset();
    tick();
    check("bp_first", 32'(bus.out_data), 32'd1);
    bus.out_ready = 1'b0;
    #1;
    check("bp_ready_off", 32'(bus.in_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("bp_hold_data",  32'(bus.out_data),  32'd1);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'h02);
    tick();
    check("bp_resume2", 32'(bus.out_data), 32'd2);
    tick();
    check("bp_resume3", 32'(bus.out_data), 32'd3);

    // Fixed mode: pointer is now 3 and must survive
    force_en  = 1'b1;
    force_sel = 3'b101;
    #1;
    check("fx_ready5", 32'(bus.in_ready), 32'h20);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("fx_data5", 32'(bus.out_data), 32'd6);
      check("fx_sel5",  32'(bus.out_sel),  32'd5);
    end
    force_sel = 3'b111;
    tick();
    check("fx_data7", 32'(bus.out_data), 32'd8);
    check("fx_sel7",  32'(bus.out_sel),  32'd7);
    bus.in_valid = 8'h7F;
    #1;
    check("fx_noreq_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("fx_drop_valid", 32'(bus.out_valid), 32'd0);
    check("fx_hold_data",  32'(bus.out_data),  32'd8);
    check("fx_hold_sel",   32'(bus.out_sel),   32'd7);
    force_en     = 1'b0;
    bus.in_valid = 8'hFF;
    #1;
    check("fx_ptr_kept", 32'(bus.in_ready), 32'h08);

    // Async reset between edges with a beat held
    tick();
    check("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("ar_valid_cleared", 32'(bus.out_valid), 32'd0);
    check("ar_data_cleared",  32'(bus.out_data),  32'd0);
    check("ar_ready_off",     32'(bus.in_ready),  32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check("ar_first_data", 32'(bus.out_data), 32'd1);
    check("ar_first_sel",  32'(bus.out_sel),  32'd0);
    tick();
    check("ar_second_data", 32'(bus.out_data), 32'd2);

`ifdef MUX_RR_ARB_CNT_EN
    do_reset();
    check("cnt_reset", 32'(xfer_count), 32'd0);
    // First beat lands on edge 1 and is consumed on edge 2
    for (int j = 0; j < 11; j++) tick();
    check("cnt_10", 32'(xfer_count), 32'd10);
    for (int j = 0; j < 65525; j++) tick();
    check("cnt_ffff", 32'(xfer_count), 32'hFFFF);
    tick();
    check("cnt_wrap", 32'(xfer_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised, registered N-way multiplexer with round-robin arbitration and valid/ready handshakes on every channel. It generalises the combinational 8-way 16-bit selector into a sequential block: many producers share one W-bit output path, and either a fair arbiter or an externally forced select chooses the source. It sits between producer channels and a single downstream consumer, and adds one register stage.

## Interface
- WIDTH, 16, data width per channel (1..64)
- CHANNELS, 8, number of input channels (2..16)
- SELW, $clog2(CHANNELS), select/index width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  channel i has a beat
- in_ready  out  CHANNELS  channel i beat accepted this cycle (combinational)
- force_en  in  1  1 = fixed-select mode, 0 = round-robin
- force_sel  in  SELW  channel used when force_en=1
- out_data  out  WIDTH  registered selected data
- out_sel  out  SELW  index of the channel that produced out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat
- xfer_count  out  16  output beats delivered (present only with MUX_RR_ARB_CNT_EN)

One clock; reset is asynchronous and active-low.

## Operation
- load = !out_valid || out_ready. The output register takes a new beat only when load=1.
- Round-robin mode: scan channels ptr, ptr+1, … mod CHANNELS. Grant goes to the first channel with in_valid=1.
- Fixed mode: grant goes to force_sel only if in_valid[force_sel]=1. A force_sel ≥ CHANNELS grants nothing.
- in_ready[i] = load && grant[i]. At most one bit is set. in_ready does not depend on in_valid[i] except through grant.
- Transfer in on channel g (load && grant valid):
  - out_data ← channel g data
  - out_sel ← g
  - out_valid ← 1
  - in round-robin mode, ptr ← (g+1) mod CHANNELS
- Fixed mode never changes ptr.
- load=1 with no grant: out_valid ← 0. out_data and out_sel hold.
- Output beat is consumed when out_valid && out_ready.
- Data is never dropped or duplicated. Each accepted input beat appears exactly once on the output.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_count=0
  - in_ready=0 while reset_n=0
- Latency: a beat accepted at edge N is visible on out_* after edge N. Throughput is 1 beat/cycle with out_ready held at 1.
- Backpressure: out_valid=1 && out_ready=0 forces all in_ready to 0. out_data and out_sel hold stable.
- Simultaneous consume and load in one cycle is allowed; this is full throughput, with no bubble.
- Wrap: ptr advances from CHANNELS-1 to 0.
- force_en and force_sel are sampled combinationally each cycle. A change affects only the next grant; the beat already in the register is untouched.
- Reset asserted mid-transfer clears the register immediately (asynchronous). The pending beat is lost by definition.
- Reset release is synchronised externally. The first grant is possible on the first edge after release.

## Configuration
- MUX_RR_ARB_CNT_EN defined:
  - xfer_count port exists.
  - It increments on every out_valid && out_ready edge and wraps from 16'hFFFF to 0.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Round-robin fairness: reset; CHANNELS=8, WIDTH=16, in_data channel i = i+1, all in_valid=1, out_ready=1. Outputs are 1,2,…,8,1,… on consecutive cycles, with out_sel 0..7 then wrap to 0.
- Sparse requests: only channels 2 and 5 valid. Outputs alternate 3,6,3,6, and in_ready alternates between bits 2 and 5.
- Backpressure: out_ready=0 for 4 cycles after the first beat. out_data stays 1 and in_ready=0. On release, the sequence resumes at 2 with no loss or duplicate.
- Fixed mode: force_en=1, force_sel=3'b101, all valid. Every output is 6 with out_sel=5. Then force_sel=3'b111 gives 8. Dropping in_valid[7] gives out_valid=0 next cycle.
- Async reset mid-stream: assert reset_n=0 between edges with out_valid=1. out_valid drops to 0 without a clock edge. After release, the first output is channel 0 (value 1).
- With MUX_RR_ARB_CNT_EN: 10 transfers give xfer_count=10. Preload 65535 transfers plus 1 gives a wrap to 0.
